// File: rtl/varredura_matriz.sv
// Column-multiplexed scan driver for the 5x7 LED matrix: double-buffered
// patterns, blanked column slots, and updates only at frame wraps.
module varredura_matriz #(
    parameter int DIV_VARREDURA = 50000,
    parameter int APAGAMENTO    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       carregar,
    input  logic [6:0] coluna1,
    input  logic [6:0] coluna2,
    input  logic [6:0] coluna3,
    input  logic [6:0] coluna4,
    input  logic [6:0] coluna5,
    output logic [6:0] linhas,
    output logic [4:0] colunas,
    output logic       quadro_fim
);

    localparam int CW = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(DIV_VARREDURA - 1);
    localparam logic [CW-1:0] LIMIAR = CW'(APAGAMENTO);

    typedef enum logic {APAGADO, ACESO} estado_t;

    estado_t       r_estado;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [6:0]    r_pendente [5];
    logic          r_tem_pendente;
    logic [6:0]    r_ativo [5];
    logic [6:0]    r_linhas;
    logic [4:0]    r_colunas;
    logic          r_quadro_fim;

    logic [6:0]    w_entrada [5];
    logic          w_fim_slot;
    logic          w_fim_quadro;
    logic [CW-1:0] w_cnt_prox;
    logic [2:0]    w_idx_prox;

    always_comb begin
        w_entrada[0] = coluna1;
        w_entrada[1] = coluna2;
        w_entrada[2] = coluna3;
        w_entrada[3] = coluna4;
        w_entrada[4] = coluna5;
        w_fim_slot   = (r_cnt == ULTIMO);
        w_fim_quadro = w_fim_slot && (r_idx == 3'd4);
        w_cnt_prox   = w_fim_slot ? '0 : r_cnt + 1'b1;
        w_idx_prox   = r_idx;
        if (w_fim_slot) begin
            w_idx_prox = (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado       <= APAGADO;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_tem_pendente <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_ativo[i] <= 7'h7f;
            end
            r_linhas       <= 7'h7f;
            r_colunas      <= 5'h1f;
            r_quadro_fim   <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_prox;
            r_idx        <= w_idx_prox;
            r_quadro_fim <= w_fim_quadro;

            // The copy reads the pre-edge pending buffer, so a strobe on the
            // wrap edge is held over to the next frame.
            if (w_fim_quadro && r_tem_pendente) begin
                for (int i = 0; i < 5; i++) begin
                    r_ativo[i] <= r_pendente[i];
                end
                r_tem_pendente <= 1'b0;
            end
            // NOTE: pending data is not reset; r_tem_pendente alone decides whether it is ever used.
            if (carregar) begin
                for (int i = 0; i < 5; i++) begin
                    r_pendente[i] <= w_entrada[i];
                end
                r_tem_pendente <= 1'b1;
            end

            // A wrap always lands in the blank phase, so r_ativo is never shown mid-update.
            case (r_estado)
                APAGADO: begin
                    if (w_cnt_prox == LIMIAR) begin
                        r_estado  <= ACESO;
                        r_colunas <= ~(5'd1 << w_idx_prox);
                        r_linhas  <= r_ativo[w_idx_prox];
                    end else begin
                        r_colunas <= 5'h1f;
                        r_linhas  <= 7'h7f;
                    end
                end
                ACESO: begin
                    if (w_fim_slot) begin
                        r_estado  <= APAGADO;
                        r_colunas <= 5'h1f;
                        r_linhas  <= 7'h7f;
                    end else begin
                        r_colunas <= ~(5'd1 << w_idx_prox);
                        r_linhas  <= r_ativo[w_idx_prox];
                    end
                end
                default: begin
                    r_estado  <= APAGADO;
                    r_colunas <= 5'h1f;
                    r_linhas  <= 7'h7f;
                end
            endcase
        end
    end

    assign linhas     = r_linhas;
    assign colunas    = r_colunas;
    assign quadro_fim = r_quadro_fim;

endmodule

// File: tb/tb_varredura_matriz.sv
// Bench for varredura_matriz: an edge-count reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_varredura_matriz;

    localparam int DIV  = 8;
    localparam int APAG = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       carregar = 1'b0;
    logic [6:0] col [5];
    logic [6:0] linhas;
    logic [4:0] colunas;
    logic       quadro_fim;

    int checks = 0;
    int errors = 0;

    // Reference model state: edges since reset release and the two buffers.
    int         e = 0;
    bit         modelo_ok = 0;
    bit         em_reset = 1;
    logic [6:0] m_ativo [5];
    logic [6:0] m_pend [5];
    bit         m_tem = 0;

    varredura_matriz #(.DIV_VARREDURA(DIV), .APAGAMENTO(APAG)) dut (
        .clk(clk), .reset(reset), .carregar(carregar),
        .coluna1(col[0]), .coluna2(col[1]), .coluna3(col[2]),
        .coluna4(col[3]), .coluna5(col[4]),
        .linhas(linhas), .colunas(colunas), .quadro_fim(quadro_fim)
    );

    always #5 clk = ~clk;

    task automatic check(input string nome, input logic [31:0] real_v, input logic [31:0] esperado);
        checks++;
        if (real_v !== esperado) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", nome, e, real_v, esperado);
        end
    endtask

    // Model update at each edge, then compare once outputs have settled.
    always @(posedge clk) begin
        automatic bit fronteira;
        if (reset) begin
            e = 0;
            em_reset = 1;
            m_tem = 0;
            for (int i = 0; i < 5; i++) m_ativo[i] = 7'h7f;
            modelo_ok = 1;
        end else begin
            e++;
            em_reset = 0;
            fronteira = (e % (5 * DIV) == 0);
            if (fronteira && m_tem) begin
                for (int i = 0; i < 5; i++) m_ativo[i] = m_pend[i];
            end
            m_tem = carregar || (m_tem && !fronteira);
            if (carregar) begin
                for (int i = 0; i < 5; i++) m_pend[i] = col[i];
            end
        end
        #1;
        if (modelo_ok) begin
            automatic int cnt = e % DIV;
            automatic int idx = (e / DIV) % 5;
            automatic logic [4:0] exp_c = 5'h1f;
            automatic logic [6:0] exp_l = 7'h7f;
            if (!em_reset && cnt >= APAG) begin
                exp_c = ~(5'd1 << idx);
                exp_l = m_ativo[idx];
            end
            check("colunas", 32'(colunas), 32'(exp_c));
            check("linhas", 32'(linhas), 32'(exp_l));
            check("quadro_fim", 32'(quadro_fim), 32'(!em_reset && e > 0 && (e % (5 * DIV) == 0)));
        end
    end

    task automatic ate(input int n);
        while (e < n) @(negedge clk);
    endtask

    task automatic aplica_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulso(input int borda, input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] c, input logic [6:0] d, input logic [6:0] f);
        ate(borda - 1);
        col[0] = a; col[1] = b; col[2] = c; col[3] = d; col[4] = f;
        carregar = 1'b1;
        @(negedge clk);
        carregar = 1'b0;
        col[0] = 7'h00; col[1] = 7'h00; col[2] = 7'h00; col[3] = 7'h00; col[4] = 7'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 5; i++) col[i] = 7'h00;

        // Reset held, then a mid-frame reset at edge 13.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_colunas", 32'(colunas), 32'(5'b11111));
        check("reset_linhas", 32'(linhas), 32'(7'b1111111));
        check("reset_quadro", 32'(quadro_fim), 32'(1'b0));
        ate(12);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_colunas", 32'(colunas), 32'(5'b11111));
        check("midreset_quadro", 32'(quadro_fim), 32'(1'b0));
        reset = 1'b0;
        ate(2);
        check("restart_col1", 32'(colunas), 32'(5'b11110));

        // Scan order without a load.
        aplica_reset(1);
        ate(10);
        check("scan_col2", 32'(colunas), 32'(5'b11101));
        ate(33);
        check("scan_col5_blank", 32'(colunas), 32'(5'b11111));
        ate(39);
        check("scan_col5", 32'(colunas), 32'(5'b01111));
        ate(40);
        check("scan_quadro40", 32'(quadro_fim), 32'(1'b1));
        ate(80);
        check("scan_quadro80", 32'(quadro_fim), 32'(1'b1));
        check("scan_linhas80", 32'(linhas), 32'(7'b1111111));

        // Load at edge 3: visible only from frame 2.
        aplica_reset(1);
        pulso(3, 7'b0111100, 7'b0011101, 7'b0110101, 7'b1000111, 7'b1110111);
        ate(39);
        check("load_dark_f1", 32'(linhas), 32'(7'b1111111));
        ate(42);
        check("load_col1_c", 32'(colunas), 32'(5'b11110));
        check("load_col1_l", 32'(linhas), 32'(7'b0111100));
        ate(60);
        check("load_col3_l", 32'(linhas), 32'(7'b0110101));
        ate(79);
        check("load_col5_c", 32'(colunas), 32'(5'b01111));
        check("load_col5_l", 32'(linhas), 32'(7'b1110111));

        // Last strobe wins.
        aplica_reset(1);
        pulso(5, 7'b0001101, 7'b0001101, 7'b0001101, 7'b0001101, 7'b0001101);
        pulso(20, 7'b1100011, 7'b1100011, 7'b1100011, 7'b1100011, 7'b1100011);
        ate(50);
        check("last_col2", 32'(linhas), 32'(7'b1100011));
        ate(76);
        check("last_col5", 32'(linhas), 32'(7'b1100011));

        // Strobe exactly on the wrap edge is deferred one frame.
        aplica_reset(1);
        pulso(10, 7'b0111100, 7'b0011101, 7'b0110101, 7'b1000111, 7'b1110111);
        pulso(40, 7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000);
        ate(42);
        check("coll_f2_A", 32'(linhas), 32'(7'b0111100));
        ate(82);
        check("coll_f3_B", 32'(linhas), 32'(7'b0000001));
        ate(118);
        check("coll_f3_B5", 32'(linhas), 32'(7'b0010000));

        // Reset discards a pending pattern.
        aplica_reset(1);
        pulso(10, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000);
        ate(19);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ate(42);
        check("discard_f2", 32'(linhas), 32'(7'b1111111));
        ate(80);
        check("discard_end", 32'(linhas), 32'(7'b1111111));
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
